// File: rtl/elastic_register_pipe.sv
// Elastic register pipeline: DEPTH valid/data stages with a combinational ready
// chain so empty stages (bubbles) are filled even while the output is stalled.
module elastic_register_pipe #(
    parameter int n     = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         recv_val,
    output logic                         recv_rdy,
    input  logic [n-1:0]                 recv_msg,
    output logic                         send_val,
    input  logic                         send_rdy,
    output logic [n-1:0]                 send_msg,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [n-1:0]     d [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] in_val;
    logic [n-1:0]     in_msg [DEPTH];
    logic [OW-1:0]    occ_count;

    // A stage can take new data if it is empty or its successor can take its data.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH-1]   = send_rdy | ~v[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            rdy[k] = rdy[k+1] | ~v[k];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic         v_reg;
            logic [n-1:0] d_reg;

            if (gi == 0) begin : g_head
                assign in_val[gi] = recv_val;
                assign in_msg[gi] = recv_msg;
            end else begin : g_body
                assign in_val[gi] = v[gi-1];
                assign in_msg[gi] = d[gi-1];
            end

            // A stalled stage (rdy low) keeps both valid and data untouched.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v_reg <= 1'b0;
                    d_reg <= '0;
                end else if (flush) begin
                    v_reg <= 1'b0;
                end else if (rdy[gi]) begin
                    v_reg <= in_val[gi];
                    if (in_val[gi]) begin
                        d_reg <= in_msg[gi];
                    end
                end
            end

            assign v[gi] = v_reg;
            assign d[gi] = d_reg;
        end
    endgenerate

    always_comb begin
        occ_count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_count = occ_count + OW'(v[k]);
        end
    end

    assign recv_rdy  = rdy[0] & ~flush;
    assign send_val  = v[DEPTH-1] & ~flush;
    assign send_msg  = d[DEPTH-1];
    assign occupancy = occ_count;

endmodule

// File: tb/tb_elastic_register_pipe.sv
// Scoreboard bench for elastic_register_pipe: a DEPTH=3 and a DEPTH=1 instance,
// selected by sel; directed pushes queue expected data, a monitor checks outputs.
module tb_elastic_register_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       recv_val;
    logic [7:0] recv_msg;
    logic       send_rdy;
    logic       flush;
    logic       sel;

    logic       rv3, rr3, sv3;
    logic [7:0] sm3;
    logic [1:0] occ3;
    logic       rv1, rr1, sv1;
    logic [7:0] sm1;
    logic [0:0] occ1;

    logic       m_recv_rdy, m_send_val;
    logic [7:0] m_send_msg;
    logic [1:0] m_occ;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    assign rv3 = recv_val & ~sel;
    assign rv1 = recv_val & sel;

    elastic_register_pipe #(.n(8), .DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .recv_val(rv3), .recv_rdy(rr3), .recv_msg(recv_msg),
        .send_val(sv3), .send_rdy(send_rdy), .send_msg(sm3), .flush(flush), .occupancy(occ3)
    );

    elastic_register_pipe #(.n(8), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .recv_val(rv1), .recv_rdy(rr1), .recv_msg(recv_msg),
        .send_val(sv1), .send_rdy(send_rdy), .send_msg(sm1), .flush(flush), .occupancy(occ1)
    );

    assign m_recv_rdy = sel ? rr1 : rr3;
    assign m_send_val = sel ? sv1 : sv3;
    assign m_send_msg = sel ? sm1 : sm3;
    assign m_occ      = sel ? {1'b0, occ1} : occ3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one message; exp_acc is the hand-derived readiness for this cycle.
    task automatic push(input logic [7:0] m, input logic exp_acc);
        recv_val = 1'b1;
        recv_msg = m;
        #1;
        chk("recv_rdy", 32'(m_recv_rdy), 32'(exp_acc));
        $display("push msg=%02h expect_accept=%0d depth=%0d", m, exp_acc, sel ? 1 : 3);
        if (exp_acc) exp_q.push_back(m);
        step();
        recv_val = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < max_cycles) begin
            step();
            cnt++;
        end
        chk("drain_complete", 32'(exp_q.size()), 32'd0);
        chk("drain_occupancy", 32'(m_occ), 32'd0);
    endtask

    // Monitor: a transfer happens at the next posedge when send_val & send_rdy here.
    always @(negedge clk) begin
        if (reset && m_send_val && send_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%02h required=none", m_send_msg);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("out  msg=%02h expected=%02h depth=%0d", m_send_msg, mon_exp, sel ? 1 : 3);
                chk("send_msg_order", 32'(m_send_msg), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        reset = 1'b0; recv_val = 1'b0; recv_msg = 8'h00;
        send_rdy = 1'b0; flush = 1'b0; sel = 1'b0;
        step();
        step();
        chk("rst_send_val", 32'(m_send_val), 32'd0);
        chk("rst_send_msg", 32'(m_send_msg), 32'd0);
        chk("rst_occupancy", 32'(m_occ), 32'd0);
        chk("rst_recv_rdy", 32'(m_recv_rdy), 32'd1);
        flush = 1'b1;
        #1;
        chk("rst_recv_rdy_flush", 32'(m_recv_rdy), 32'd0);
        flush = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("post_rst_occupancy", 32'(m_occ), 32'd0);

        // Single message, latency DEPTH-1
        send_rdy = 1'b1;
        push(8'hA5, 1'b1);
        chk("single_occ_e0", 32'(m_occ), 32'd1);
        chk("single_val_e0", 32'(m_send_val), 32'd0);
        step();
        chk("single_val_e1", 32'(m_send_val), 32'd0);
        step();
        chk("single_val_e2", 32'(m_send_val), 32'd1);
        chk("single_msg_e2", 32'(m_send_msg), 32'hA5);
        step();
        chk("single_occ_e3", 32'(m_occ), 32'd0);
        chk("single_val_e3", 32'(m_send_val), 32'd0);

        // Streaming 0x01..0x10; 13 delivered by the time the last is accepted
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b1);
        chk("stream_occ", 32'(m_occ), 32'd3);
        drain(10);

        // Backpressure
        send_rdy = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        push(8'h44, 1'b0);
        chk("bp_occ_full", 32'(m_occ), 32'd3);
        chk("bp_head_held", 32'(m_send_msg), 32'h11);
        send_rdy = 1'b1;
        push(8'h44, 1'b1);
        drain(10);

        // Bubble collapse
        send_rdy = 1'b0;
        push(8'h01, 1'b1);
        step();
        push(8'h02, 1'b1);
        chk("bubble_occ_a", 32'(m_occ), 32'd2);
        step();
        chk("bubble_occ_b", 32'(m_occ), 32'd2);
        chk("bubble_head", 32'(m_send_msg), 32'h01);
        chk("bubble_recv_rdy", 32'(m_recv_rdy), 32'd1);
        send_rdy = 1'b1;
        drain(10);

        // Flush of a full pipe with a simultaneous offer
        send_rdy = 1'b0;
        push(8'h61, 1'b1);
        push(8'h62, 1'b1);
        push(8'h63, 1'b1);
        chk("flush_pre_occ", 32'(m_occ), 32'd3);
        flush = 1'b1; recv_val = 1'b1; recv_msg = 8'h77; send_rdy = 1'b1;
        #1;
        chk("flush_recv_rdy", 32'(m_recv_rdy), 32'd0);
        chk("flush_send_val", 32'(m_send_val), 32'd0);
        step();
        flush = 1'b0; recv_val = 1'b0;
        exp_q.delete();
        chk("flush_occ", 32'(m_occ), 32'd0);
        chk("flush_send_val_after", 32'(m_send_val), 32'd0);
        repeat (4) step();
        chk("flush_occ_later", 32'(m_occ), 32'd0);

        // Asynchronous reset mid-stream, asserted between edges
        send_rdy = 1'b0;
        push(8'h81, 1'b1);
        push(8'h82, 1'b1);
        push(8'h83, 1'b1);
        chk("arst_pre_occ", 32'(m_occ), 32'd3);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_send_val", 32'(m_send_val), 32'd0);
        chk("arst_send_msg", 32'(m_send_msg), 32'd0);
        chk("arst_occ", 32'(m_occ), 32'd0);
        chk("arst_recv_rdy", 32'(m_recv_rdy), 32'd1);
        exp_q.delete();
        step();
        reset = 1'b1;
        step();
        send_rdy = 1'b1;
        push(8'h91, 1'b1);
        chk("arst_post_occ", 32'(m_occ), 32'd1);
        drain(8);

        // DEPTH = 1 instance
        sel = 1'b1;
        step();
        push(8'hA5, 1'b1);
        chk("d1_single_occ", 32'(m_occ), 32'd1);
        chk("d1_single_val", 32'(m_send_val), 32'd1);
        chk("d1_single_msg", 32'(m_send_msg), 32'hA5);
        step();
        chk("d1_single_occ_after", 32'(m_occ), 32'd0);
        send_rdy = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b0);
        chk("d1_bp_occ", 32'(m_occ), 32'd1);
        chk("d1_bp_head", 32'(m_send_msg), 32'h11);
        send_rdy = 1'b1;
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        push(8'h44, 1'b1);
        drain(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
